beta_pipeline_sequencer: RTL and testbench
==========================================

Name: beta_pipeline_sequencer

Overview:
- Parametrised successor to the fixed 3-stage pipeline control unit.
- Sequences an N-stage in-order pipeline using per-boundary occupancy tracking and backpressure stall propagation.
- Adds precise flushes driven by any stage, a fetch halt/drain mode, and per-boundary saturating stall counters.
- Sits between the stage modules and the inter-stage pipe registers. Stage 0 is fetch; pipe j sits between stage j and stage j+1.

Parameters:
- StageNum, 3, number of pipeline stages S (legal range 2..8); there are S-1 pipes.
- CntWidth, 16, width of each stall counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- stg_busy_i  in  S  stage k is still working and cannot accept a new input.
- stg_done_i  in  S  stage k has a result to push into pipe k. Held until accepted. Bit S-1 is ignored.
- flush_req_i  in  S  stage k requests a flush of all younger work (stages and pipes with index < k). Bit 0 is ignored.
- halt_i  in  1  suppress new fetches; in-flight work drains.
- cnt_clr_i  in  1  clear all stall counters.
- fetch_en_o  out  1  stage 0 may start a fetch this cycle.
- pip_stall_o  out  S-1  pipe j must hold its contents; stage j must keep done asserted.
- pip_flush_o  out  S-1  invalidate pipe j this cycle.
- stg_kill_o  out  S  abort in-flight work in stage k this cycle.
- idle_o  out  1  all pipes empty and no stage busy.
- stall_cnt_o  out  (S-1)*CntWidth  packed stall counters; pipe j occupies bits [j*CntWidth +: CntWidth].

Behaviour:
- State: occ[S-2:0] (pipe holds an unconsumed item) and S-1 stall counters. Nothing else is registered.
- Reset (rst_i=1 at a clock edge): occ=0, counters=0. Outputs are combinational and therefore follow occ: after reset, pip_stall_o=0, pip_flush_o=0, stg_kill_o=0, idle_o=1 if stg_busy_i=0, fetch_en_o=~halt_i & ~stg_busy_i[0].
- Flush resolution: K = highest k in 1..S-1 with flush_req_i[k]=1; K=0 if none. The oldest requester wins.
  - fl_pipe[j] = (j < K); fl_stg[k] = (k < K).
- Consume, evaluated combinationally from j=S-2 down to 0:
  - consume[j] = occ[j] & ~stg_busy_i[j+1] & ~stall_dn[j+1].
  - stall_dn[j+1] = pip_stall_o[j+1] for j+1 ≤ S-2; 0 for the last stage.
  - The backpressure chain has no registers, so a stall at the tail reaches pipe 0 in the same cycle.
- pip_stall_o[j] = occ[j] & ~consume[j] & ~fl_pipe[j].
- load[j] = stg_done_i[j] & ~pip_stall_o[j] & ~fl_pipe[j] & ~fl_stg[j].
- occ next:
  - fl_pipe[j]: 0.
  - otherwise: load[j] | (occ[j] & ~consume[j]).
  - A simultaneous consume and load keeps occ=1 (full throughput).
- pip_flush_o = fl_pipe; stg_kill_o = fl_stg. Both are single-cycle, same cycle as the request. A flush overrides load, consume and stall on the affected pipes.
- fetch_en_o = ~halt_i & ~stg_busy_i[0] & ~pip_stall_o[0] & (K==0). Fetch is suppressed during the flush cycle and may resume the next cycle.
- idle_o = (occ==0) & (stg_busy_i==0).
- Counters:
  - Counter j increments when pip_stall_o[j]=1.
  - Saturates at all-ones; no wrap.
  - cnt_clr_i has priority over increment.
  - rst_i has priority over everything.
- Reset asserted mid-operation discards all occupancy immediately; no flush outputs are generated by the reset itself.

Test Plan:
- S=3, stg_busy_i=0, stg_done_i[1:0]=11 every cycle -> occ=11 steady, pip_stall_o=00, fetch_en_o=1 each cycle, counters stay 0.
- S=3, occ=11, stg_busy_i[2]=1 for 4 cycles -> pip_stall_o=11 and fetch_en_o=0 in each of those cycles, both counters=4. The cycle after busy drops, pip_stall_o=00.
- S=4, occ=111, flush_req_i=1000 together with flush_req_i[2] -> K=3: pip_flush_o=111, stg_kill_o=0111, fetch_en_o=0. Next cycle occ=000 and idle_o=1 if no stage is busy.
- S=3, flush_req_i[2]=1 while stg_done_i[0]=1 and occ[0]=0 -> load suppressed; occ stays 00 next cycle.
- CntWidth=4, pipe 0 stalled for 20 cycles -> counter 0 = 4'hF (saturated). cnt_clr_i=1 together with a stall -> counter = 0.
- halt_i=1 with occ=11 and no busy stages -> fetch_en_o=0; occ drains to 00 within 2 cycles; idle_o=1. rst_i=1 mid-stall -> occ=0 and counters=0 at the next edge.

Source files
------------

// File: rtl/beta_pipeline_sequencer.sv
// Control unit for an N-stage in-order pipeline: per-pipe occupancy, backpressure
// stalls, oldest-wins precise flushes, fetch halt and saturating per-pipe stall counters.
module beta_pipeline_sequencer #(
    parameter int StageNum = 3,
    parameter int CntWidth = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [StageNum-1:0]              stg_busy_i,
    input  logic [StageNum-1:0]              stg_done_i,
    input  logic [StageNum-1:0]              flush_req_i,
    input  logic                             halt_i,
    input  logic                             cnt_clr_i,
    output logic                             fetch_en_o,
    output logic [StageNum-2:0]              pip_stall_o,
    output logic [StageNum-2:0]              pip_flush_o,
    output logic [StageNum-1:0]              stg_kill_o,
    output logic                             idle_o,
    output logic [(StageNum-1)*CntWidth-1:0] stall_cnt_o
);

    localparam int PipeNum = StageNum - 1;

    logic [PipeNum-1:0]  occ_q, occ_d;
    logic [CntWidth-1:0] cnt_q [PipeNum];
    logic [CntWidth-1:0] cnt_d [PipeNum];
    logic [PipeNum-1:0]  consume;
    logic [PipeNum-1:0]  load;
    logic                stallDn;
    logic                flushAny;
    int                  flushIdx;
    logic                unusedBits;

    // The last stage has no output pipe and stage 0 has no younger work to flush.
    assign unusedBits = stg_done_i[StageNum-1] ^ flush_req_i[0];

    // The oldest requesting stage determines how far back the flush reaches.
    always_comb begin
        flushIdx = 0;
        for (int k = 1; k < StageNum; k++) begin
            if (flush_req_i[k]) flushIdx = k;
        end
        pip_flush_o = '0;
        for (int j = 0; j < PipeNum; j++) pip_flush_o[j] = (j < flushIdx);
        stg_kill_o = '0;
        for (int k = 0; k < StageNum; k++) stg_kill_o[k] = (k < flushIdx);
    end

    assign flushAny = |flush_req_i[StageNum-1:1];

    // Unregistered backpressure chain: a tail stall reaches pipe 0 in the same cycle.
    always_comb begin
        consume     = '0;
        pip_stall_o = '0;
        stallDn     = 1'b0;
        for (int j = PipeNum - 1; j >= 0; j--) begin
            consume[j]     = occ_q[j] & ~stg_busy_i[j+1] & ~stallDn;
            pip_stall_o[j] = occ_q[j] & ~consume[j] & ~pip_flush_o[j];
            stallDn        = pip_stall_o[j];
        end
    end

    always_comb begin
        load  = '0;
        occ_d = '0;
        for (int j = 0; j < PipeNum; j++) begin
            load[j]  = stg_done_i[j] & ~pip_stall_o[j] & ~pip_flush_o[j] & ~stg_kill_o[j];
            occ_d[j] = pip_flush_o[j] ? 1'b0 : (load[j] | (occ_q[j] & ~consume[j]));
        end
    end

    always_comb begin
        for (int j = 0; j < PipeNum; j++) begin
            cnt_d[j] = cnt_q[j];
            if (cnt_clr_i) begin
                cnt_d[j] = '0;
            end else if (pip_stall_o[j] && (cnt_q[j] != '1)) begin
                cnt_d[j] = cnt_q[j] + CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_q <= '0;
            for (int j = 0; j < PipeNum; j++) cnt_q[j] <= '0;
        end else begin
            occ_q <= occ_d;
            for (int j = 0; j < PipeNum; j++) cnt_q[j] <= cnt_d[j];
        end
    end

    assign fetch_en_o = ~halt_i & ~stg_busy_i[0] & ~pip_stall_o[0] & ~flushAny;
    assign idle_o     = (occ_q == '0) & (stg_busy_i == '0);

    always_comb begin
        stall_cnt_o = '0;
        for (int j = 0; j < PipeNum; j++) stall_cnt_o[j*CntWidth +: CntWidth] = cnt_q[j];
    end

endmodule

// File: tb/tb_beta_pipeline_sequencer.sv
// Scoreboard bench for beta_pipeline_sequencer (4 stages, 4-bit counters):
// directed scenarios followed by randomized traffic against a behavioural model.
module tb_beta_pipeline_sequencer;

    localparam int S  = 4;
    localparam int P  = S - 1;
    localparam int CW = 4;
    localparam int CntMax = (1 << CW) - 1;

    typedef struct packed {
        logic          fetch;
        logic [P-1:0]  stall;
        logic [P-1:0]  flush;
        logic [S-1:0]  kill;
        logic          idle;
        logic [P*CW-1:0] cnt;
    } exp_t;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [S-1:0]    stg_busy_i;
    logic [S-1:0]    stg_done_i;
    logic [S-1:0]    flush_req_i;
    logic            halt_i;
    logic            cnt_clr_i;
    logic            fetch_en_o;
    logic [P-1:0]    pip_stall_o;
    logic [P-1:0]    pip_flush_o;
    logic [S-1:0]    stg_kill_o;
    logic            idle_o;
    logic [P*CW-1:0] stall_cnt_o;

    exp_t sbQueue[$];
    bit   modelOcc [P];
    int   modelCnt [P];
    int   assertCount = 0;
    int   failCount   = 0;

    beta_pipeline_sequencer #(.StageNum(S), .CntWidth(CW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .stg_busy_i  (stg_busy_i),
        .stg_done_i  (stg_done_i),
        .flush_req_i (flush_req_i),
        .halt_i      (halt_i),
        .cnt_clr_i   (cnt_clr_i),
        .fetch_en_o  (fetch_en_o),
        .pip_stall_o (pip_stall_o),
        .pip_flush_o (pip_flush_o),
        .stg_kill_o  (stg_kill_o),
        .idle_o      (idle_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic compareField(input string name, input int act, input int expv);
        assertCount++;
        if (act !== expv) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareField("fetch_en", int'(fetch_en_o), int'(e.fetch));
        compareField("pip_stall", int'(pip_stall_o), int'(e.stall));
        compareField("pip_flush", int'(pip_flush_o), int'(e.flush));
        compareField("stg_kill", int'(stg_kill_o), int'(e.kill));
        compareField("idle", int'(idle_o), int'(e.idle));
        for (int j = 0; j < P; j++)
            compareField($sformatf("stall_cnt%0d", j), int'(stall_cnt_o[j*CW +: CW]), int'(e.cnt[j*CW +: CW]));
    endtask

    // Drives one cycle of inputs, predicts this cycle's outputs, then advances the model.
    task automatic applyStimulus(input logic [S-1:0] busy, input logic [S-1:0] done,
                                 input logic [S-1:0] flush, input logic halt,
                                 input logic clr, input logic rst);
        exp_t e;
        int   oldest;
        bit   downstreamHeld;
        bit   leaves;
        bit   held [P];
        bit   anyOcc;
        @(posedge clk_i);
        #1;
        stg_busy_i  = busy;
        stg_done_i  = done;
        flush_req_i = flush;
        halt_i      = halt;
        cnt_clr_i   = clr;
        rst_i       = rst;

        oldest = 0;
        for (int k = 1; k < S; k++) if (flush[k]) oldest = k;

        downstreamHeld = 1'b0;
        for (int j = P - 1; j >= 0; j--) begin
            leaves  = modelOcc[j] && !busy[j+1] && !downstreamHeld;
            held[j] = modelOcc[j] && !leaves && (j >= oldest);
            downstreamHeld = held[j];
        end

        anyOcc = 1'b0;
        e = '0;
        for (int j = 0; j < P; j++) begin
            e.stall[j] = held[j];
            e.flush[j] = (j < oldest);
            e.cnt[j*CW +: CW] = CW'(modelCnt[j]);
            if (modelOcc[j]) anyOcc = 1'b1;
        end
        for (int k = 0; k < S; k++) e.kill[k] = (k < oldest);
        e.fetch = !halt && !busy[0] && !held[0] && (oldest == 0);
        e.idle  = !anyOcc && (busy == '0);
        sbQueue.push_back(e);

        for (int j = 0; j < P; j++) begin
            if (rst) begin
                modelOcc[j] = 1'b0;
                modelCnt[j] = 0;
            end else begin
                if (j < oldest) modelOcc[j] = 1'b0;
                else            modelOcc[j] = held[j] || (done[j] && !held[j] && (j >= oldest));
                if (clr)          modelCnt[j] = 0;
                else if (held[j]) modelCnt[j] = (modelCnt[j] >= CntMax) ? CntMax : modelCnt[j] + 1;
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (sbQueue.size() > 0) begin
                e = sbQueue.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : driver
        rst_i       = 1'b1;
        stg_busy_i  = '0;
        stg_done_i  = '0;
        flush_req_i = '0;
        halt_i      = 1'b0;
        cnt_clr_i   = 1'b0;
        for (int j = 0; j < P; j++) begin
            modelOcc[j] = 1'b0;
            modelCnt[j] = 0;
        end
        repeat (2) @(posedge clk_i);

        applyStimulus(4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        repeat (5) applyStimulus(4'b0000, 4'b0111, 4'b0000, 0, 0, 0);
        repeat (4) applyStimulus(4'b1000, 4'b0111, 4'b0000, 0, 0, 0);
        applyStimulus(4'b0000, 4'b0111, 4'b0000, 0, 0, 0);
        applyStimulus(4'b0000, 4'b0111, 4'b1100, 0, 0, 0);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        applyStimulus(4'b0000, 4'b0001, 4'b0100, 0, 0, 0);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        repeat (21) applyStimulus(4'b0010, 4'b0001, 4'b0000, 0, 0, 0);
        applyStimulus(4'b0010, 4'b0001, 4'b0000, 0, 1, 0);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        repeat (2) applyStimulus(4'b0000, 4'b0111, 4'b0000, 0, 0, 0);
        repeat (3) applyStimulus(4'b0000, 4'b0000, 4'b0000, 1, 0, 0);
        repeat (3) applyStimulus(4'b1000, 4'b0111, 4'b0000, 0, 0, 0);
        applyStimulus(4'b1000, 4'b0111, 4'b0000, 0, 0, 1);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 0, 0, 0);

        for (int n = 0; n < 400; n++) begin
            logic [S-1:0] busy, done, flush;
            for (int k = 0; k < S; k++) begin
                busy[k] = ($urandom_range(0, 3) == 0);
                done[k] = ($urandom_range(0, 9) < 7);
            end
            flush = ($urandom_range(0, 9) == 0) ? S'($urandom) : '0;
            applyStimulus(busy, done, flush,
                          ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 29) == 0),
                          ($urandom_range(0, 99) == 0));
        end

        repeat (2) @(posedge clk_i);
        compareField("scoreboard_drained", sbQueue.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
